// File: rtl/uart_debug_loader_pkg.sv
// Shared definitions for the UART debug loader: command bytes, response
// bytes, FSM state encoding and a small helper for single-byte responses.
package uart_debug_loader_pkg;

    // Host command bytes
    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_PC   = 8'h50;

    // Response bytes
    localparam logic [7:0] RSP_ACK    = 8'h06;
    localparam logic [7:0] RSP_NAK    = 8'h15;
    localparam logic [7:0] RSP_HALTED = 8'h48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_RUN,
        ST_STEP,
        ST_RESP
    } state_e;

    // Pack a one-byte response into the 4-byte response buffer (byte 0 first).
    function automatic logic [31:0] rsp_byte(input logic [7:0] b);
        return {24'h000000, b};
    endfunction

endpackage

// File: rtl/uart_debug_resp_tx.sv
// Response transmitter: takes up to four bytes (byte 0 first) plus a count on
// a start pulse, pushes them into the TX FIFO one per cycle while it has room,
// then pulses tx_start/done in the cycle after the final push.
module uart_debug_resp_tx (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_start,
    input  logic [31:0] i_bytes,
    input  logic [2:0]  i_cnt,
    input  logic        i_tx_full,
    output logic        o_wr,
    output logic [7:0]  o_wdata,
    output logic        o_tx_start,
    output logic        o_done
);

    logic        busy_q, busy_d;
    logic [2:0]  rem_q, rem_d;
    logic [31:0] sh_q, sh_d;
    logic        fin_q, fin_d;

    // Pushes only happen while enabled and the FIFO has room; data is zero
    // whenever no push is in progress.
    assign o_wr       = i_en & busy_q & ~i_tx_full;
    assign o_wdata    = o_wr ? sh_q[7:0] : 8'h00;
    assign o_tx_start = i_en & fin_q;
    assign o_done     = i_en & fin_q;

    // Next-state: accept a new response when idle, shift out one byte per
    // successful push, and raise the finish flag after the last byte.
    always_comb begin
        busy_d = busy_q;
        rem_d  = rem_q;
        sh_d   = sh_q;
        fin_d  = fin_q;
        if (i_en) begin
            fin_d = 1'b0;
            if (busy_q) begin
                if (!i_tx_full) begin
                    sh_d  = {8'h00, sh_q[31:8]};
                    rem_d = rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        busy_d = 1'b0;
                        fin_d  = 1'b1;
                    end
                end
            end else if (i_start) begin
                sh_d  = i_bytes;
                rem_d = i_cnt;
                if (i_cnt == 3'd0) begin
                    fin_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            busy_q <= 1'b0;
            rem_q  <= 3'd0;
            sh_q   <= 32'h0;
            fin_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            rem_q  <= rem_d;
            sh_q   <= sh_d;
            fin_q  <= fin_d;
        end
    end

endmodule

// File: rtl/uart_debug_loader.sv
// Host-side debug loader between the UART FIFOs and the CPU subsystem.
// Decodes command bytes, streams a program image into instruction memory,
// gates the CPU enable for run/step/halt and returns status/PC bytes.
// Optional build macro: LOADER_TIMEOUT_EN adds an inter-byte timeout during
// a load (abort with NAK after TIMEOUT_CYCLES idle cycles).
module uart_debug_loader
    import uart_debug_loader_pkg::*;
#(
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int NB_PC           = 32,
    parameter int NB_UART_DATA    = 8,
    parameter int TIMEOUT_CYCLES  = 5_000_000
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
    input  logic                       i_uart_rx_empty,
    output logic                       o_uart_rd,
    output logic [NB_UART_DATA-1:0]    o_uart_wdata,
    output logic                       o_uart_wr,
    input  logic                       i_uart_tx_full,
    output logic                       o_uart_tx_start,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
    output logic                       o_cpu_en,
    output logic                       o_cpu_rst,
    input  logic                       i_cpu_halt,
    input  logic [NB_PC-1:0]           i_cpu_pc
);

    state_e                     state_q, state_d;
    logic [7:0]                 len_lo_q, len_lo_d;
    logic [15:0]                words_left_q, words_left_d;
    logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]                word_q, word_d;
    logic [1:0]                 bcnt_q, bcnt_d;
    logic [31:0]                rsp_bytes_q, rsp_bytes_d;
    logic [2:0]                 rsp_cnt_q, rsp_cnt_d;
    logic                       rsp_start_q, rsp_start_d;
    logic                       ret_run_q, ret_run_d;
    logic                       cpu_rst_q, cpu_rst_d;

    logic                       rsp_go;
    logic [31:0]                rsp_word;
    logic [2:0]                 rsp_n;
    logic                       rx_state;
    logic                       take;
    logic [7:0]                 rx_byte;
    logic [7:0]                 tx_wdata;
    logic                       tx_done;

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign rx_byte  = i_uart_rx_data[7:0];
    assign rx_state = (state_q == ST_IDLE) || (state_q == ST_LEN0) ||
                      (state_q == ST_LEN1) || (state_q == ST_DATA) ||
                      (state_q == ST_RUN);
    // A byte is popped and sampled in the same cycle; reset keeps it quiet.
    assign take      = i_rst & i_en & ~i_uart_rx_empty & rx_state;
    assign o_uart_rd = take;

    assign o_imem_we    = i_en & (state_q == ST_WRITE);
    assign o_imem_addr  = o_imem_we ? addr_q : '0;
    assign o_imem_wdata = o_imem_we ? NB_INSTRUCTION'(word_q) : '0;
    assign o_cpu_en     = i_en & ((state_q == ST_RUN) || (state_q == ST_STEP));
    assign o_cpu_rst    = i_en & cpu_rst_q;
    assign o_uart_wdata = NB_UART_DATA'(tx_wdata);

    // Next-state and datapath decode for the command FSM
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        word_d       = word_q;
        bcnt_d       = bcnt_q;
        rsp_bytes_d  = rsp_bytes_q;
        rsp_cnt_d    = rsp_cnt_q;
        rsp_start_d  = rsp_start_q & ~i_en;
        cpu_rst_d    = cpu_rst_q & ~i_en;
        ret_run_d    = ret_run_q;
        rsp_go       = 1'b0;
        rsp_word     = 32'h0;
        rsp_n        = 3'd0;
`ifdef LOADER_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        if (i_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        rsp_go   = 1'b1;
                        rsp_n    = 3'd1;
                        case (rx_byte)
                            CMD_LOAD: begin
                                rsp_go  = 1'b0;
                                state_d = ST_LEN0;
                            end
                            CMD_RUN: begin
                                rsp_word  = rsp_byte(RSP_ACK);
                                ret_run_d = 1'b1;
                            end
                            CMD_STEP: begin
                                rsp_go  = 1'b0;
                                state_d = ST_STEP;
                            end
                            CMD_HALT: rsp_word = rsp_byte(RSP_ACK);
                            CMD_PC: begin
                                rsp_word = i_cpu_pc[31:0];
                                rsp_n    = 3'd4;
                            end
                            default:  rsp_word = rsp_byte(RSP_NAK);
                        endcase
                    end
                end
                ST_LEN0: begin
                    if (take) begin
                        len_lo_d = rx_byte;
                        state_d  = ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (take) begin
                        if ({rx_byte, len_lo_q} == 16'h0000) begin
                            rsp_go   = 1'b1;
                            rsp_word = rsp_byte(RSP_ACK);
                            rsp_n    = 3'd1;
                        end else begin
                            words_left_d = {rx_byte, len_lo_q};
                            addr_d       = '0;
                            bcnt_d       = 2'd0;
                            state_d      = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (take) begin
                        // Bytes arrive LSB first, so shift in from the top.
                        word_d = {rx_byte, word_q[31:8]};
                        bcnt_d = bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    addr_d       = addr_q + 1'b1;
                    words_left_d = words_left_q - 16'd1;
                    if (words_left_q == 16'd1) begin
                        cpu_rst_d = 1'b1;
                        rsp_go    = 1'b1;
                        rsp_word  = rsp_byte(RSP_ACK);
                        rsp_n     = 3'd1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_RUN: begin
                    // Halt wins over a simultaneous halt byte; the byte is
                    // still popped, so only one response goes out.
                    if (i_cpu_halt) begin
                        rsp_go   = 1'b1;
                        rsp_word = rsp_byte(RSP_HALTED);
                        rsp_n    = 3'd1;
                    end else if (take && (rx_byte == CMD_HALT)) begin
                        rsp_go   = 1'b1;
                        rsp_word = rsp_byte(RSP_ACK);
                        rsp_n    = 3'd1;
                    end
                end
                ST_STEP: begin
                    rsp_go   = 1'b1;
                    rsp_word = rsp_byte(RSP_ACK);
                    rsp_n    = 3'd1;
                end
                ST_RESP: begin
                    if (tx_done) begin
                        state_d   = ret_run_q ? ST_RUN : ST_IDLE;
                        ret_run_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef LOADER_TIMEOUT_EN
            if ((state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA)) begin
                if (take) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    to_cnt_d = '0;
                    rsp_go   = 1'b1;
                    rsp_word = rsp_byte(RSP_NAK);
                    rsp_n    = 3'd1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end else begin
                to_cnt_d = '0;
            end
`endif
        end
        if (rsp_go) begin
            state_d     = ST_RESP;
            rsp_start_d = 1'b1;
            rsp_bytes_d = rsp_word;
            rsp_cnt_d   = rsp_n;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            len_lo_q     <= 8'h00;
            words_left_q <= 16'h0000;
            addr_q       <= '0;
            word_q       <= 32'h0;
            bcnt_q       <= 2'd0;
            rsp_bytes_q  <= 32'h0;
            rsp_cnt_q    <= 3'd0;
            rsp_start_q  <= 1'b0;
            ret_run_q    <= 1'b0;
            cpu_rst_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            bcnt_q       <= bcnt_d;
            rsp_bytes_q  <= rsp_bytes_d;
            rsp_cnt_q    <= rsp_cnt_d;
            rsp_start_q  <= rsp_start_d;
            ret_run_q    <= ret_run_d;
            cpu_rst_q    <= cpu_rst_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Inter-byte idle counter for loads
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    uart_debug_resp_tx u_resp_tx (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_start    (rsp_start_q),
        .i_bytes    (rsp_bytes_q),
        .i_cnt      (rsp_cnt_q),
        .i_tx_full  (i_uart_tx_full),
        .o_wr       (o_uart_wr),
        .o_wdata    (tx_wdata),
        .o_tx_start (o_uart_tx_start),
        .o_done     (tx_done)
    );

endmodule

// File: tb/tb_uart_debug_loader.sv
// Directed bench for uart_debug_loader: RX FIFO model, TX/imem/CPU recorders
// and a linear sequence of hand-computed checks.
module tb_uart_debug_loader;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        o_uart_rd;
    logic [7:0]  o_uart_wdata;
    logic        o_uart_wr;
    logic        i_uart_tx_full;
    logic        o_uart_tx_start;
    logic        o_imem_we;
    logic [9:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_cpu_en;
    logic        o_cpu_rst;
    logic        i_cpu_halt;
    logic [31:0] i_cpu_pc;

    int checks;
    int errors;

    // Recorder state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    int          tx_cyc_q[$];
    logic [9:0]  we_addr_q[$];
    logic [31:0] we_data_q[$];
    int cyc, last_rd_cyc, txstart_cnt, txstart_cyc, we_cnt, last_we_cyc;
    int cpurst_cnt, cpurst_cyc, en_cnt, en_rise_cyc, wr_full_cnt;
    logic en_prev = 1'b0;

    uart_debug_loader #(.TIMEOUT_CYCLES(100)) dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_en            (i_en),
        .i_uart_rx_data  (rx_data),
        .i_uart_rx_empty (rx_empty),
        .o_uart_rd       (o_uart_rd),
        .o_uart_wdata    (o_uart_wdata),
        .o_uart_wr       (o_uart_wr),
        .i_uart_tx_full  (i_uart_tx_full),
        .o_uart_tx_start (o_uart_tx_start),
        .o_imem_we       (o_imem_we),
        .o_imem_addr     (o_imem_addr),
        .o_imem_wdata    (o_imem_wdata),
        .o_cpu_en        (o_cpu_en),
        .o_cpu_rst       (o_cpu_rst),
        .i_cpu_halt      (i_cpu_halt),
        .i_cpu_pc        (i_cpu_pc)
    );

    always #5 clk = ~clk;

    // FWFT RX FIFO model plus output recorders, sampled at the active edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_uart_rd) begin
            if (rxq.size() > 0) void'(rxq.pop_front());
            last_rd_cyc <= cyc;
        end
        rx_empty <= (rxq.size() == 0);
        rx_data  <= (rxq.size() != 0) ? rxq[0] : 8'h00;
        if (o_uart_wr) begin
            txq.push_back(o_uart_wdata);
            tx_cyc_q.push_back(cyc);
            if (i_uart_tx_full) wr_full_cnt <= wr_full_cnt + 1;
        end
        if (o_uart_tx_start) begin
            txstart_cnt <= txstart_cnt + 1;
            txstart_cyc <= cyc;
        end
        if (o_imem_we) begin
            we_cnt <= we_cnt + 1;
            we_addr_q.push_back(o_imem_addr);
            we_data_q.push_back(o_imem_wdata);
            last_we_cyc <= cyc;
        end
        if (o_cpu_rst) begin
            cpurst_cnt <= cpurst_cnt + 1;
            cpurst_cyc <= cyc;
        end
        if (o_cpu_en) en_cnt <= en_cnt + 1;
        if (o_cpu_en && !en_prev) en_rise_cyc <= cyc;
        en_prev <= o_cpu_en;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic wait_start(input int target, input int budget, input string tag);
        int n = 0;
        while (txstart_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(txstart_cnt >= target), 64'd1);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({o_uart_rd, o_uart_wr, o_uart_wdata, o_uart_tx_start, o_imem_we,
                    o_imem_addr, o_imem_wdata, o_cpu_en, o_cpu_rst});
    endfunction

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, w0, s0, r0, e0, f0;
        i_rst = 1'b0; i_en = 1'b1; i_uart_tx_full = 1'b0; i_cpu_halt = 1'b0; i_cpu_pc = 32'h0;
        repeat (3) step();
        check("reset_outputs", all_outs(), 64'd0);
        i_rst = 1'b1;
        step();

        // Normal two-word load
        t0 = txq.size(); w0 = we_cnt; s0 = txstart_cnt; r0 = cpurst_cnt;
        push(8'h4C); push(8'h02); push(8'h00);
        push(8'h78); push(8'h56); push(8'h34); push(8'h12);
        push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
        wait_start(s0 + 1, 200, "load_done");
        check("load_we_cnt", 64'(we_cnt - w0), 64'd2);
        check("load_addr0", 64'(we_addr_q[w0]), 64'd0);
        check("load_data0", 64'(we_data_q[w0]), 64'h12345678);
        check("load_addr1", 64'(we_addr_q[w0+1]), 64'd1);
        check("load_data1", 64'(we_data_q[w0+1]), 64'hDEADBEEF);
        check("load_cpurst_cnt", 64'(cpurst_cnt - r0), 64'd1);
        check("load_cpurst_timing", 64'(cpurst_cyc - last_we_cyc), 64'd1);
        check("load_tx_len", 64'(txq.size() - t0), 64'd1);
        check("load_tx_ack", 64'(txq[t0]), 64'h06);

        // Zero-length load
        t0 = txq.size(); w0 = we_cnt; s0 = txstart_cnt; r0 = cpurst_cnt;
        push(8'h4C); push(8'h00); push(8'h00);
        wait_start(s0 + 1, 100, "zero_done");
        check("zero_we_cnt", 64'(we_cnt - w0), 64'd0);
        check("zero_cpurst", 64'(cpurst_cnt - r0), 64'd0);
        check("zero_tx_ack", 64'(txq[t0]), 64'h06);

        // Address wrap: 1025 words, word k holds value k
        t0 = txq.size(); w0 = we_cnt; s0 = txstart_cnt;
        push(8'h4C); push(8'h01); push(8'h04);
        for (int k = 0; k < 1025; k++) begin
            push(k[7:0]); push(k[15:8]); push(8'h00); push(8'h00);
        end
        wait_start(s0 + 1, 8000, "wrap_done");
        check("wrap_we_cnt", 64'(we_cnt - w0), 64'd1025);
        check("wrap_addr_1023", 64'(we_addr_q[w0+1023]), 64'h3FF);
        check("wrap_addr_last", 64'(we_addr_q[w0+1024]), 64'd0);
        check("wrap_data_last", 64'(we_data_q[w0+1024]), 64'h400);
        check("wrap_tx_ack", 64'(txq[t0]), 64'h06);

        // Run, then CPU halt
        t0 = txq.size(); s0 = txstart_cnt;
        push(8'h52);
        wait_start(s0 + 1, 100, "run_ack_done");
        step();
        check("run_tx_ack", 64'(txq[t0]), 64'h06);
        check("run_en_after_start", 64'(en_rise_cyc - txstart_cyc), 64'd1);
        repeat (20) step();
        check("run_en_high", 64'(o_cpu_en), 64'd1);
        t0 = txq.size(); s0 = txstart_cnt;
        i_cpu_halt = 1'b1;
        step();
        i_cpu_halt = 1'b0;
        check("halt_en_low", 64'(o_cpu_en), 64'd0);
        wait_start(s0 + 1, 100, "halt_done");
        check("halt_tx_len", 64'(txq.size() - t0), 64'd1);
        check("halt_tx_byte", 64'(txq[t0]), 64'h48);

        // Run, then halt byte and CPU halt in the same cycle
        s0 = txstart_cnt;
        push(8'h52);
        wait_start(s0 + 1, 100, "run2_ack_done");
        repeat (3) step();
        t0 = txq.size(); s0 = txstart_cnt;
        push(8'h48);
        step();
        i_cpu_halt = 1'b1;
        step();
        i_cpu_halt = 1'b0;
        check("sim_en_low", 64'(o_cpu_en), 64'd0);
        wait_start(s0 + 1, 100, "sim_done");
        repeat (10) step();
        check("sim_tx_len", 64'(txq.size() - t0), 64'd1);
        check("sim_tx_byte", 64'(txq[t0]), 64'h48);
        check("sim_rx_consumed", 64'(rxq.size()), 64'd0);

        // Single step
        t0 = txq.size(); s0 = txstart_cnt; e0 = en_cnt;
        push(8'h53);
        wait_start(s0 + 1, 100, "step_done");
        check("step_en_cycles", 64'(en_cnt - e0), 64'd1);
        check("step_tx_ack", 64'(txq[t0]), 64'h06);

        // PC readback and minimum response latency
        t0 = txq.size(); s0 = txstart_cnt;
        i_cpu_pc = 32'h00000104;
        push(8'h50);
        wait_start(s0 + 1, 100, "pc_done");
        check("pc_tx_len", 64'(txq.size() - t0), 64'd4);
        check("pc_byte0", 64'(txq[t0]), 64'h04);
        check("pc_byte1", 64'(txq[t0+1]), 64'h01);
        check("pc_byte2", 64'(txq[t0+2]), 64'h00);
        check("pc_byte3", 64'(txq[t0+3]), 64'h00);
        check("pc_latency", 64'(tx_cyc_q[t0] - last_rd_cyc), 64'd2);

        // Block disabled: nothing consumed, then resumes
        t0 = txq.size(); s0 = txstart_cnt;
        i_en = 1'b0;
        push(8'h48);
        repeat (6) step();
        check("dis_rx_held", 64'(rxq.size()), 64'd1);
        check("dis_no_tx", 64'(txq.size() - t0), 64'd0);
        i_en = 1'b1;
        wait_start(s0 + 1, 100, "dis_done");
        check("dis_tx_ack", 64'(txq[t0]), 64'h06);

        // TX backpressure with an unknown command
        t0 = txq.size(); s0 = txstart_cnt; f0 = wr_full_cnt;
        i_uart_tx_full = 1'b1;
        push(8'h7A);
        repeat (10) step();
        check("bp_no_tx", 64'(txq.size() - t0), 64'd0);
        check("bp_no_wr_full", 64'(wr_full_cnt - f0), 64'd0);
        i_uart_tx_full = 1'b0;
        wait_start(s0 + 1, 100, "bp_done");
        check("bp_tx_len", 64'(txq.size() - t0), 64'd1);
        check("bp_tx_nak", 64'(txq[t0]), 64'h15);

        // Reset in the middle of a load
        w0 = we_cnt;
        push(8'h4C); push(8'h01); push(8'h00); push(8'hAA); push(8'hBB);
        repeat (8) step();
        check("rst_mid_consumed", 64'(rxq.size()), 64'd0);
        i_rst = 1'b0;
        #1;
        check("rst_mid_outputs", all_outs(), 64'd0);
        step();
        i_rst = 1'b1;
        step();
        t0 = txq.size(); s0 = txstart_cnt;
        push(8'h50);
        wait_start(s0 + 1, 100, "rst_idle_done");
        check("rst_idle_pc_len", 64'(txq.size() - t0), 64'd4);
        check("rst_no_write", 64'(we_cnt - w0), 64'd0);

`ifdef LOADER_TIMEOUT_EN
        // Inter-byte timeout aborts the load with NAK
        t0 = txq.size(); w0 = we_cnt; s0 = txstart_cnt;
        push(8'h4C); push(8'h01); push(8'h00); push(8'hAA);
        wait_start(s0 + 1, 300, "to_done");
        check("to_tx_nak", 64'(txq[t0]), 64'h15);
        check("to_no_write", 64'(we_cnt - w0), 64'd0);
        check("to_delay", 64'((tx_cyc_q[t0] - last_rd_cyc >= 100) &&
                              (tx_cyc_q[t0] - last_rd_cyc <= 105)), 64'd1);
`else
        // Without the timeout a stalled load simply waits
        t0 = txq.size(); w0 = we_cnt; s0 = txstart_cnt;
        push(8'h4C); push(8'h01); push(8'h00); push(8'hAA);
        repeat (150) step();
        check("wait_no_tx", 64'(txq.size() - t0), 64'd0);
        push(8'hBB); push(8'hCC); push(8'hDD);
        wait_start(s0 + 1, 100, "wait_done");
        check("wait_tx_ack", 64'(txq[t0]), 64'h06);
        check("wait_data", 64'(we_data_q[w0]), 64'hDDCCBBAA);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
